dds_sweep_ctrl: RTL and testbench
=================================

Name: dds_sweep_ctrl

Overview:
Sequencer that drives the DDS phase-increment input (fre) through a programmed frequency sweep.
- Steps the increment from f_start toward f_stop by f_step.
- Holds each point for a programmable dwell, counted in clk cycles.
- Supports single-shot, repeating and up/down (triangle) sweeps.
- Sits between the key/choice configuration logic and the DDS address accumulator, in the 125 MHz DDS clock domain.

Parameters:
FRE_W, 10, width of phase increment (matches 10-bit DDS ROM address step)
DWELL_W, 24, width of dwell counter (max ~134 ms per point at 125 MHz)

Ports:
clk  in  1  DDS clock (125 MHz)
rst_n  in  1  reset, asynchronous, active-low
start  in  1  single-cycle request; sampled only in IDLE
abort  in  1  single-cycle request; honoured in any state
f_start  in  FRE_W  first sweep increment
f_stop  in  FRE_W  last sweep increment
f_step  in  FRE_W  increment delta per point
dwell  in  DWELL_W  cycles each point is held; 0 treated as 1
mode  in  2  0=single up, 1=repeat up, 2=up/down continuous, 3=reserved (treated as 0)
fre_out  out  FRE_W  phase increment to DDS
busy  out  1  sweep in progress
step_tick  out  1  1-cycle pulse, coincident with each new fre_out value
done  out  1  1-cycle pulse at end of a mode-0 sweep or an error
err  out  1  sticky config error, cleared by next accepted start

Behaviour:
Reset values: fre_out=0, busy=0, step_tick=0, done=0, err=0, state=IDLE, dir=up.

States:
- IDLE -> LOAD on start & ~abort. Latch f_start, f_stop, f_step, dwell, mode into shadow registers. Clear err.
- LOAD -> DONE (err<=1) if shadow f_step==0 or f_start>f_stop; fre_out is not changed.
- LOAD -> DWELL otherwise. fre_out<=f_start, step_tick=1, dwell counter<=dwell_eff-1, busy=1.
- DWELL: decrement counter. At 0 -> STEP.
- STEP computes the next point; see the rules below.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.

STEP rules:
- Next-point arithmetic uses FRE_W+1 bits, so no wrap-around.
- up: if cur==f_stop, apply the end rule; else next=min(cur+f_step, f_stop).
- down: if cur==f_start, apply the end rule; else next=max(cur-f_step, f_start), computed signed/extended.
- End rule: mode 0 -> DONE. Mode 1 -> next=f_start. Mode 2 -> reverse dir and take one step in the new direction; endpoints are not repeated.
- STEP -> DWELL loads the new fre_out, asserts step_tick and reloads the counter. STEP occupies one cycle.

Timing:
- Each point is visible on fre_out for exactly dwell_eff+1 cycles; the STEP cycle holds the old value.
- First fre_out update occurs 2 cycles after start is sampled.

Boundary and concurrency rules:
- abort in any non-IDLE state -> IDLE next cycle. busy=0, no done, fre_out holds its last value.
- abort and start in the same cycle: abort wins and start is dropped.
- start while busy is ignored. Input port changes during a sweep have no effect (shadow registers).
- f_start==f_stop is valid: a single point. Mode 0 -> done after one dwell; modes 1/2 hold the point indefinitely, with step_tick each dwell.
- Asynchronous reset mid-sweep returns all outputs to reset values immediately.

Decomposition:
- dds_pkg holds:
  - state encoding (IDLE, LOAD, DWELL, STEP, DONE)
  - mode constants (MODE_SINGLE=0, MODE_REPEAT=1, MODE_UPDOWN=2)
  - default FRE_W=10 and DWELL_W=24
- One sub-module, dds_dwell_timer: loadable down-counter with load, value, and expire (counter==0 & enable) outputs.
- Next-point min/max arithmetic stays in the top level.

Test Plan:
- Single up sweep: f_start=10, f_stop=30, f_step=10, dwell=3, mode 0 -> fre_out 10,20,30, each held 4 cycles; 3 step_tick pulses; done 1 cycle after the last hold; busy falls with done.
- Non-multiple stop: f_start=10, f_stop=25, f_step=10, dwell=0, mode 0 -> sequence 10,20,25, each held 2 cycles; no value >25.
- Up/down mode: f_start=10, f_stop=30, f_step=10, dwell=1, mode 2 -> 10,20,30,20,10,20,30,... with no repeated endpoints; no done pulse.
- Edge of range: FRE_W=10, f_start=1000, f_stop=1023, f_step=20, mode 1 -> 1000,1020,1023,1000,... with no wrap to small values.
- Error config: f_step=0, or f_start=40 with f_stop=20 -> err=1 and a done pulse 2 cycles after start; fre_out unchanged. The next valid start clears err.
- Abort/start collisions: abort during the second point -> busy=0 next cycle, fre_out frozen at 20, no done. start and abort asserted together in IDLE -> no sweep starts. start while busy -> ignored.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared types and defaults for the DDS frequency-sweep sequencer.
package dds_pkg;

  localparam int FRE_W_DEF   = 10;
  localparam int DWELL_W_DEF = 24;

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_REPEAT = 2'd1;
  localparam logic [1:0] MODE_UPDOWN = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DWELL,
    ST_STEP,
    ST_DONE
  } state_e;

endpackage

// File: rtl/dds_dwell_timer.sv
// Loadable down-counter that times how long each sweep point is held.
module dds_dwell_timer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         expire
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                   cnt_d = load_val;
    else if (en && cnt_q != '0) cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;

  assign value  = cnt_q;
  assign expire = en && (cnt_q == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Steps the DDS phase increment through a programmed frequency sweep
// (single, repeating or triangle), holding each point for a dwell time.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int FRE_W   = FRE_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [FRE_W-1:0]   f_start,
  input  logic [FRE_W-1:0]   f_stop,
  input  logic [FRE_W-1:0]   f_step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [1:0]         mode,
  output logic [FRE_W-1:0]   fre_out,
  output logic               busy,
  output logic               step_tick,
  output logic               done,
  output logic               err
);

  state_e               state_q, state_d;
  logic [FRE_W-1:0]     fre_q, fre_d;
  logic                 tick_q, tick_d;
  logic                 err_q, err_d;
  logic                 dir_up_q, dir_up_d;
  logic [FRE_W-1:0]     f_start_q, f_start_d, f_stop_q, f_stop_d, f_step_q, f_step_d;
  logic [DWELL_W-1:0]   dwell_m1_q, dwell_m1_d;
  logic [1:0]           mode_q, mode_d;

  logic                 tmr_load, tmr_expire;
  logic [DWELL_W-1:0]   tmr_value;

  // Next-point candidates, one bit wider so the top of the range never wraps.
  logic [FRE_W:0]       up_sum, dn_floor;
  logic [FRE_W-1:0]     up_next, dn_next, nxt;
  logic                 go;

  always_comb begin
    up_sum   = {1'b0, fre_q} + {1'b0, f_step_q};
    up_next  = (up_sum > {1'b0, f_stop_q}) ? f_stop_q : up_sum[FRE_W-1:0];
    dn_floor = {1'b0, f_start_q} + {1'b0, f_step_q};
    dn_next  = ({1'b0, fre_q} < dn_floor) ? f_start_q : (fre_q - f_step_q);
  end

  always_comb begin
    state_d    = state_q;
    fre_d      = fre_q;
    tick_d     = 1'b0;
    err_d      = err_q;
    dir_up_d   = dir_up_q;
    f_start_d  = f_start_q;
    f_stop_d   = f_stop_q;
    f_step_d   = f_step_q;
    dwell_m1_d = dwell_m1_q;
    mode_d     = mode_q;
    tmr_load   = 1'b0;
    nxt        = fre_q;
    go         = 1'b1;

    if (abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start && !abort) begin
          f_start_d  = f_start;
          f_stop_d   = f_stop;
          f_step_d   = f_step;
          dwell_m1_d = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
          mode_d     = (mode == 2'd3) ? MODE_SINGLE : mode;
          err_d      = 1'b0;
          state_d    = ST_LOAD;
        end
        ST_LOAD: begin
          if (f_step_q == '0 || f_start_q > f_stop_q) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            fre_d    = f_start_q;
            tick_d   = 1'b1;
            tmr_load = 1'b1;
            dir_up_d = 1'b1;
            state_d  = ST_DWELL;
          end
        end
        ST_DWELL: if (tmr_expire) state_d = ST_STEP;
        ST_STEP: begin
          if (dir_up_q) begin
            if (fre_q != f_stop_q)          nxt = up_next;
            else if (mode_q == MODE_SINGLE) go  = 1'b0;
            else if (mode_q == MODE_REPEAT) nxt = f_start_q;
            else begin
              dir_up_d = 1'b0;
              nxt      = dn_next;
            end
          end else begin
            // Only triangle sweeps travel downward.
            if (fre_q != f_start_q) nxt = dn_next;
            else begin
              dir_up_d = 1'b1;
              nxt      = up_next;
            end
          end
          if (go) begin
            fre_d    = nxt;
            tick_d   = 1'b1;
            tmr_load = 1'b1;
            state_d  = ST_DWELL;
          end else begin
            state_d  = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      fre_q      <= '0;
      tick_q     <= 1'b0;
      err_q      <= 1'b0;
      dir_up_q   <= 1'b1;
      f_start_q  <= '0;
      f_stop_q   <= '0;
      f_step_q   <= '0;
      dwell_m1_q <= '0;
      mode_q     <= MODE_SINGLE;
    end else begin
      state_q    <= state_d;
      fre_q      <= fre_d;
      tick_q     <= tick_d;
      err_q      <= err_d;
      dir_up_q   <= dir_up_d;
      f_start_q  <= f_start_d;
      f_stop_q   <= f_stop_d;
      f_step_q   <= f_step_d;
      dwell_m1_q <= dwell_m1_d;
      mode_q     <= mode_d;
    end
  end

  dds_dwell_timer #(.W(DWELL_W)) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .en       (state_q == ST_DWELL),
    .load_val (dwell_m1_q),
    .value    (tmr_value),
    .expire   (tmr_expire)
  );

  assign fre_out   = fre_q;
  assign step_tick = tick_q;
  assign err       = err_q;
  assign done      = (state_q == ST_DONE);
  assign busy      = (state_q == ST_LOAD) || (state_q == ST_DWELL) || (state_q == ST_STEP);

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: directed sweeps push expected
// step_tick/done events; a negedge monitor pops and compares them.
module tb_dds_sweep_ctrl;

  localparam int FRE_W   = 10;
  localparam int DWELL_W = 24;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0, abort = 1'b0;
  logic [FRE_W-1:0]   f_start = '0, f_stop = '0, f_step = '0;
  logic [DWELL_W-1:0] dwell = '0;
  logic [1:0]         mode = '0;
  logic [FRE_W-1:0]   fre_out;
  logic               busy, step_tick, done, err;

  dds_sweep_ctrl #(.FRE_W(FRE_W), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .f_start(f_start), .f_stop(f_stop), .f_step(f_step),
    .dwell(dwell), .mode(mode),
    .fre_out(fre_out), .busy(busy), .step_tick(step_tick),
    .done(done), .err(err)
  );

  always #4 clk = ~clk;

  typedef struct {
    bit is_done;
    int val;   // fre_out for a tick, err for a done
    int gap;   // cycles since previous event; 0 = not checked
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0, failures = 0;
  int   cyc = 0, last_evt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_tick(input int v, input int gap);
    exp_t x;
    x.is_done = 1'b0; x.val = v; x.gap = gap;
    exp_q.push_back(x);
  endtask

  task automatic push_done(input int e_err, input int gap);
    exp_t x;
    x.is_done = 1'b1; x.val = e_err; x.gap = gap;
    exp_q.push_back(x);
  endtask

  task automatic cfg(input int fs, input int fp, input int st, input int dw, input int md);
    f_start = FRE_W'(fs); f_stop = FRE_W'(fp); f_step = FRE_W'(st);
    dwell = DWELL_W'(dw); mode = 2'(md);
  endtask

  // Called at a negedge; returns one negedge later with start low again.
  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic abort_pulse();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      cyc++;
      if (step_tick || done) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_event tick=%0d done=%0d fre_out=%0d (t=%0t)",
                   step_tick, done, fre_out, $time);
        end else begin
          e = exp_q.pop_front();
          chk("evt_kind_is_done", int'(done), int'(e.is_done));
          if (e.is_done) begin
            chk("done_err", int'(err), e.val);
            chk("done_busy_low", int'(busy), 0);
          end else begin
            chk("tick_fre_out", int'(fre_out), e.val);
          end
          if (e.gap != 0) chk("event_spacing", cyc - last_evt, e.gap);
        end
        last_evt = cyc;
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_fre_out", int'(fre_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_tick", int'(step_tick), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);

    // Single up sweep, dwell 3 -> 4-cycle holds; a start mid-sweep is ignored.
    cfg(10, 30, 10, 3, 0);
    push_tick(10, 0); push_tick(20, 4); push_tick(30, 4); push_done(0, 4);
    start_pulse();
    chk("t1_busy_load", int'(busy), 1);
    repeat (4) @(negedge clk);
    cfg(5, 8, 1, 0, 1);
    start_pulse();
    repeat (14) @(negedge clk);
    chk("t1_drained", exp_q.size(), 0);
    chk("t1_fre_hold", int'(fre_out), 30);
    chk("t1_busy_end", int'(busy), 0);

    // Stop not a multiple of step: clamp to 25, 2-cycle holds.
    cfg(10, 25, 10, 0, 0);
    push_tick(10, 0); push_tick(20, 2); push_tick(25, 2); push_done(0, 2);
    start_pulse();
    repeat (11) @(negedge clk);
    chk("t2_drained", exp_q.size(), 0);
    chk("t2_fre_hold", int'(fre_out), 25);

    // Zero step -> error; done two cycles after start, fre_out untouched.
    cfg(10, 30, 0, 3, 0);
    push_done(1, 0);
    start_pulse();
    chk("t3_done_early", int'(done), 0);
    @(negedge clk);
    chk("t3_done", int'(done), 1);
    chk("t3_err", int'(err), 1);
    chk("t3_fre_kept", int'(fre_out), 25);
    @(negedge clk);
    chk("t3_done_one_cycle", int'(done), 0);
    chk("t3_err_sticky", int'(err), 1);

    // Reversed range -> error; err drops on accepted start then rises again.
    cfg(40, 20, 5, 3, 0);
    push_done(1, 0);
    start_pulse();
    chk("t3b_err_cleared_on_start", int'(err), 0);
    @(negedge clk);
    chk("t3b_err", int'(err), 1);
    chk("t3b_fre_kept", int'(fre_out), 25);
    @(negedge clk);
    chk("t3_drained", exp_q.size(), 0);

    // Triangle sweep: endpoints not repeated, no done; abort at 8th point.
    cfg(10, 30, 10, 1, 2);
    push_tick(10, 0); push_tick(20, 2); push_tick(30, 2); push_tick(20, 2);
    push_tick(10, 2); push_tick(20, 2); push_tick(30, 2); push_tick(20, 2);
    start_pulse();
    chk("t4_err_cleared", int'(err), 0);
    repeat (15) @(negedge clk);
    abort_pulse();
    chk("t4_abort_busy", int'(busy), 0);
    chk("t4_abort_fre", int'(fre_out), 20);
    repeat (6) @(negedge clk);
    chk("t4_drained", exp_q.size(), 0);

    // Abort during the second point of a single sweep: no done, fre_out frozen.
    cfg(10, 30, 10, 3, 0);
    push_tick(10, 0); push_tick(20, 4);
    start_pulse();
    repeat (6) @(negedge clk);
    chk("t5_busy_before", int'(busy), 1);
    abort_pulse();
    chk("t5_busy_after", int'(busy), 0);
    chk("t5_done_after", int'(done), 0);
    repeat (20) @(negedge clk);
    chk("t5_drained", exp_q.size(), 0);
    chk("t5_fre_frozen", int'(fre_out), 20);

    // start and abort together in IDLE: nothing starts.
    cfg(100, 200, 50, 0, 0);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("t6_busy", int'(busy), 0);
    repeat (5) @(negedge clk);
    chk("t6_busy_later", int'(busy), 0);
    chk("t6_fre", int'(fre_out), 20);

    // Top of range, repeat mode: 1020+20 clamps to 1023, then wraps to f_start.
    cfg(1000, 1023, 20, 0, 1);
    push_tick(1000, 0); push_tick(1020, 2); push_tick(1023, 2);
    push_tick(1000, 2); push_tick(1020, 2); push_tick(1023, 2);
    start_pulse();
    repeat (11) @(negedge clk);
    abort_pulse();
    chk("t7_fre", int'(fre_out), 1023);
    repeat (4) @(negedge clk);
    chk("t7_drained", exp_q.size(), 0);

    // Single point, mode 0: one tick, done after one 3-cycle hold.
    cfg(50, 50, 1, 2, 0);
    push_tick(50, 0); push_done(0, 3);
    start_pulse();
    repeat (8) @(negedge clk);
    chk("t8_drained", exp_q.size(), 0);

    // Single point, triangle: point held with a tick every dwell.
    cfg(50, 50, 1, 2, 2);
    push_tick(50, 0); push_tick(50, 3); push_tick(50, 3);
    start_pulse();
    repeat (7) @(negedge clk);
    abort_pulse();
    repeat (4) @(negedge clk);
    chk("t8b_drained", exp_q.size(), 0);

    // Async reset with err set clears everything at once.
    cfg(40, 20, 5, 3, 0);
    push_done(1, 0);
    start_pulse();
    repeat (2) @(negedge clk);
    chk("t9_err_set", int'(err), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t9_rst_err", int'(err), 0);
    chk("t9_rst_fre", int'(fre_out), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Async reset mid-sweep.
    cfg(10, 30, 10, 3, 1);
    push_tick(10, 0);
    @(negedge clk);
    start_pulse();
    repeat (2) @(negedge clk);
    chk("t10_busy_mid", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t10_rst_fre", int'(fre_out), 0);
    chk("t10_rst_busy", int'(busy), 0);
    chk("t10_rst_tick", int'(step_tick), 0);
    chk("t10_rst_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("t10_busy_after", int'(busy), 0);
    chk("t10_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
